// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO for a UART: turns each rising edge of the receiver's
// byte-complete level into one write and buffers bytes for a FWFT consumer.
module uart_rx_fifo #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_done,
  input  logic                     rd_en,
  input  logic                     clr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             done_q;
  logic             wr, pop, push;

  // A write while full only lands if the head leaves in the same cycle.
  always_comb begin
    wr         = rx_done & ~done_q;
    pop        = rd_en & ~empty;
    push       = wr & (~full | pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (wr && full && !pop) overflow_d = 1'b1;
    end
  end

  // done_q resets high so a level already present at reset release is not a new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= rx_done;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr && push) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rd_data     = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a
// negedge monitor checks every pop against the queue head.
module tb_uart_rx_fifo;

  localparam int DEPTH    = 8;
  localparam int WIDTH    = 8;
  localparam int AF_LEVEL = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] rx_data;
  logic             rx_done;
  logic             rd_en;
  logic             clr;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [3:0]       count;
  logic             almost_full;
  logic             overflow;

  int               testsRun    = 0;
  int               testsFailed = 0;
  logic [WIDTH-1:0] expQ [$];
  logic             expOvf = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rd_en       (rd_en),
    .clr         (clr),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pops are committed on the next rising edge; check the head now.
  always @(negedge clk) begin
    if (!rst && !clr && rd_en && !empty) begin
      if (expQ.size() == 0) begin
        checkOutput("pop while model empty", {31'b0, empty}, 32'd1);
      end else begin
        logic [WIDTH-1:0] expByte;
        expByte = expQ.pop_front();
        checkOutput("rd_data on pop", {24'b0, rd_data}, {24'b0, expByte});
      end
    end
  end

  task automatic checkState(input string tag);
    checkOutput({tag, " count"}, {28'b0, count}, expQ.size());
    checkOutput({tag, " empty"}, {31'b0, empty}, {31'b0, expQ.size() == 0});
    checkOutput({tag, " full"}, {31'b0, full}, {31'b0, expQ.size() == DEPTH});
    checkOutput({tag, " almost_full"}, {31'b0, almost_full},
                {31'b0, expQ.size() >= AF_LEVEL});
    checkOutput({tag, " overflow"}, {31'b0, overflow}, {31'b0, expOvf});
    if (expQ.size() > 0)
      checkOutput({tag, " head"}, {24'b0, rd_data}, {24'b0, expQ[0]});
  endtask

  task automatic applyStimulus(input logic doneV, input logic [WIDTH-1:0] dataV,
                               input logic rdV, input logic clrV, input logic rstV);
    rx_done = doneV;
    rx_data = dataV;
    rd_en   = rdV;
    clr     = clrV;
    rst     = rstV;
    @(posedge clk);
    #1;
  endtask

  task automatic writeByte(input logic [WIDTH-1:0] b, input logic withRead);
    if (expQ.size() == DEPTH && !withRead) expOvf = 1'b1;
    else expQ.push_back(b);
    applyStimulus(1'b1, b, withRead, 1'b0, 1'b0);
    applyStimulus(1'b0, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popByte();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic fillPass(input logic [WIDTH-1:0] base, input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      writeByte(base + WIDTH'(i), 1'b0);
      checkState(tag);
    end
    for (int i = 0; i < DEPTH; i++) popByte();
    checkState({tag, " drained"});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rx_done = 1'b0; rx_data = '0; rd_en = 1'b0; clr = 1'b0; rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkState("reset");

    // A single long rx_done level yields exactly one stored byte.
    expQ.push_back(8'h41);
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    checkState("long level first cycle");
    for (int i = 0; i < 19; i++) applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
    checkState("long level end");
    popByte();
    popByte();
    checkState("read while empty");

    fillPass(8'h10, "pass1");
    fillPass(8'h20, "pass2 wrap");

    // Overflow drops the byte; clr flushes everything.
    for (int i = 0; i < DEPTH; i++) writeByte(8'h30 + 8'(i), 1'b0);
    writeByte(8'hAA, 1'b0);
    checkState("overflow");
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    expQ.delete();
    expOvf = 1'b0;
    checkState("after clr");

    // Simultaneous write and pop while full.
    for (int i = 0; i < DEPTH; i++) writeByte(8'h50 + 8'(i), 1'b0);
    writeByte(8'h55, 1'b1);
    checkState("full write+pop");
    for (int i = 0; i < DEPTH; i++) popByte();
    checkState("full write+pop drained");

    writeByte(8'h3C, 1'b1);
    checkState("empty write+read");
    popByte();

    // Reset mid-stream with rx_done held high through release.
    for (int i = 0; i < 5; i++) writeByte(8'h60 + 8'(i), 1'b0);
    checkState("five stored");
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    expQ.delete();
    expOvf = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    checkState("held done after reset");
    applyStimulus(1'b0, 8'h99, 1'b0, 1'b0, 1'b0);
    writeByte(8'h77, 1'b0);
    checkState("write after reset");
    popByte();
    checkState("final");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
